run_monitor: RTL and testbench
==============================

RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/register width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-file address width (2**REG_ADDR_W registers).
REQ-003 SHALL have parameter DONE_REG, default 9, register whose first write marks program completion.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50, max cycles in RUN before timeout.
REQ-005 SHALL have parameter STALL_LIMIT, default 8, consecutive unchanged-PC cycles flagged as a hang (0 = disabled).
REQ-006 SHALL have parameter CNT_W, default 16, width of cycle and write counters.
REQ-007 SHALL have parameter CHECK_EN, default 0, 1 = compare final DONE_REG value against EXPECT_VAL.
REQ-008 SHALL have parameter EXPECT_VAL, default 0, expected final DONE_REG value.
REQ-009 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-010 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-011 SHALL have port rf_we_i  input  1  register-file write enable (writeback stage).
REQ-012 SHALL have port rf_waddr_i  input  REG_ADDR_W  write address.
REQ-013 SHALL have port rf_wdata_i  input  XLEN  write data.
REQ-014 SHALL have port pc_i  input  XLEN  current fetch PC.
REQ-015 SHALL have ports done_o, pass_o, fail_o, timeout_o, hang_o  output  1 each  status flags.
REQ-016 SHALL have ports cycle_cnt_o, wr_cnt_o  output  CNT_W each  elapsed cycles / counted writes.
REQ-017 SHALL have port final_val_o  output  XLEN  captured DONE_REG value.
REQ-018 SHALL have port written_mask_o  output  2**REG_ADDR_W  bit i set once register i written.
REQ-019 SHALL have port state_o  output  2  FSM state encoding.

Function
REQ-020 FSM states SHALL be RUN=0, DRAIN=1, PASS=2, FAIL=3.
REQ-021 In RUN, rf_we_i=1 with rf_waddr_i=DONE_REG SHALL capture rf_wdata_i into final_val_o and move to DRAIN next cycle.
REQ-022 DRAIN SHALL last exactly one cycle, then go to FAIL if CHECK_EN=1 and final_val_o!=EXPECT_VAL, else PASS.
REQ-023 Timeout: in RUN, cycle_cnt_o==TIMEOUT_CYCLES-1 without a DONE_REG write SHALL go to FAIL and set timeout_o.
REQ-024 Hang: pc_i equal to previous-cycle pc_i for STALL_LIMIT consecutive cycles in RUN SHALL go to FAIL and set hang_o; any PC change clears the stall count.
REQ-025 Same-cycle priority SHALL be DONE_REG write > timeout > hang; only the winning cause flag is set.
REQ-026 PASS and FAIL SHALL be sticky until reset; all inputs ignored there, counters frozen.
REQ-027 done_o SHALL be 1 in PASS or FAIL; pass_o = (state==PASS); fail_o = (state==FAIL).
REQ-028 cycle_cnt_o SHALL increment every cycle in RUN and DRAIN, saturating at 2**CNT_W-1.
REQ-029 wr_cnt_o SHALL increment on each rf_we_i with rf_waddr_i!=0 in RUN/DRAIN, saturating.
REQ-030 Writes to address 0 SHALL never set written_mask_o[0] nor count.
REQ-031 A DRAIN-cycle write to DONE_REG SHALL update written_mask_o but not final_val_o.

Reset
REQ-032 Asserting reset at any time, including mid-DRAIN, SHALL asynchronously force state RUN and all outputs, counters, mask, stall count and previous-PC register to 0.
REQ-033 First post-reset cycle SHALL not count as a stall (previous-PC valid bit cleared by reset).

Structure
REQ-034 State encoding and default parameter constants SHALL live in shared package run_monitor_pkg.
REQ-035 Saturating counters SHALL be one reusable sub-module sat_counter (params WIDTH; ports clk, reset, clr, inc, q), instantiated for cycle, write and stall counts.

Verification
REQ-036 Write x1..x8, then x9=42 at cycle 20, CHECK_EN=0 -> DRAIN at 21, pass_o=1 at 22, final_val_o=42, wr_cnt_o=9.
REQ-037 CHECK_EN=1, EXPECT_VAL=7, x9 written 8 -> fail_o=1, timeout_o=0, hang_o=0.
REQ-038 No x9 write, PC incrementing -> fail_o and timeout_o=1 with cycle_cnt_o=49.
REQ-039 PC held at 0x10 for 8 cycles at cycle 5 -> fail_o, hang_o=1 at cycle 13; 7-cycle hold then change -> no hang.
REQ-040 x9 write on cycle 49 (timeout cycle) -> pass path, timeout_o=0.
REQ-041 Reset asserted during DRAIN -> state_o=0, all outputs 0 immediately, new run completes normally.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared definitions for the run monitor.
//   state_e    - monitor FSM state encoding (also driven out on state_o)
//   *_DEF      - default values for the run_monitor parameters
package run_monitor_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StPass  = 2'd2,
        StFail  = 2'd3
    } state_e;

    localparam int unsigned XLEN_DEF           = 32;
    localparam int unsigned REG_ADDR_W_DEF     = 5;
    localparam int unsigned DONE_REG_DEF       = 9;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 50;
    localparam int unsigned STALL_LIMIT_DEF    = 8;
    localparam int unsigned CNT_W_DEF          = 16;
    localparam int unsigned CHECK_EN_DEF       = 0;
    localparam int unsigned EXPECT_VAL_DEF     = 0;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value.
//   clk   - clock, rising edge
//   reset - asynchronous active-high clear
//   clr   - synchronous clear, wins over inc
//   inc   - count enable
//   q     - current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/run_monitor.sv
// run_monitor: watches a core's register-file writeback and fetch PC and decides when a
// test program has finished and whether it passed.
//   clk, reset             - clock; asynchronous active-high reset
//   rf_we_i/waddr_i/wdata_i - register-file write port observed at writeback
//   pc_i                   - current fetch PC, used for hang detection
//   done_o/pass_o/fail_o   - run finished / passed / failed
//   timeout_o, hang_o      - failure cause (at most one set)
//   cycle_cnt_o, wr_cnt_o  - elapsed active cycles / writes to non-zero registers
//   final_val_o            - value of the first DONE_REG write
//   written_mask_o         - bit i set once register i has been written
//   state_o                - FSM state
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned XLEN           = XLEN_DEF,
    parameter int unsigned REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int unsigned DONE_REG       = DONE_REG_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned STALL_LIMIT    = STALL_LIMIT_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned CHECK_EN       = CHECK_EN_DEF,
    parameter int unsigned EXPECT_VAL     = EXPECT_VAL_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rf_we_i,
    input  logic [REG_ADDR_W-1:0]    rf_waddr_i,
    input  logic [XLEN-1:0]          rf_wdata_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic                     hang_o,
    output logic [CNT_W-1:0]         cycle_cnt_o,
    output logic [CNT_W-1:0]         wr_cnt_o,
    output logic [XLEN-1:0]          final_val_o,
    output logic [2**REG_ADDR_W-1:0] written_mask_o,
    output logic [1:0]               state_o
);

    localparam int unsigned NREGS   = 2**REG_ADDR_W;
    localparam int unsigned STALL_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    state_e                r_state;
    logic [XLEN-1:0]       r_final;
    logic                  r_timeout;
    logic                  r_hang;
    logic [NREGS-1:0]      r_mask;
    logic [XLEN-1:0]       r_pc_prev;
    logic                  r_pc_vld;

    logic                  w_active;
    logic                  w_run;
    logic                  w_wr_nz;
    logic                  w_done_wr;
    logic                  w_timeout;
    logic                  w_stall;
    logic                  w_hang;
    logic                  w_cyc_inc;
    logic [CNT_W-1:0]      w_cyc;
    logic [CNT_W-1:0]      w_wr;
    logic [STALL_W-1:0]    w_stall_cnt;

    assign w_run     = (r_state == StRun);
    assign w_active  = w_run || (r_state == StDrain);
    assign w_wr_nz   = rf_we_i && (rf_waddr_i != '0);
    assign w_done_wr = w_run && rf_we_i && (rf_waddr_i == REG_ADDR_W'(DONE_REG));
    assign w_timeout = w_run && (w_cyc == CNT_W'(TIMEOUT_CYCLES - 1));
    // The first cycle after reset has no previous PC, so it can never be a stall.
    assign w_stall   = w_run && r_pc_vld && (pc_i == r_pc_prev);
    assign w_hang    = (STALL_LIMIT != 0) && w_stall &&
                       (w_stall_cnt == STALL_W'(STALL_LIMIT - 1));

    // A RUN cycle that aborts into FAIL is not counted, so cycle_cnt_o keeps the
    // index of the failing cycle; DRAIN always counts.
    assign w_cyc_inc = (r_state == StDrain) ||
                       (w_run && (w_done_wr || !(w_timeout || w_hang)));

    sat_counter #(.WIDTH(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (w_cyc_inc),
        .q     (w_cyc)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (w_active && w_wr_nz),
        .q     (w_wr)
    );

    // Counts consecutive cycles whose PC equals the previous cycle's PC.
    sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_active && !w_stall),
        .inc   (w_stall),
        .q     (w_stall_cnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StRun;
            r_final   <= '0;
            r_timeout <= 1'b0;
            r_hang    <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (w_done_wr) begin
                        r_final <= rf_wdata_i;
                        r_state <= StDrain;
                    end else if (w_timeout) begin
                        r_timeout <= 1'b1;
                        r_state   <= StFail;
                    end else if (w_hang) begin
                        r_hang  <= 1'b1;
                        r_state <= StFail;
                    end
                end
                StDrain: begin
                    if ((CHECK_EN != 0) && (r_final != XLEN'(EXPECT_VAL))) begin
                        r_state <= StFail;
                    end else begin
                        r_state <= StPass;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask    <= '0;
            r_pc_prev <= '0;
            r_pc_vld  <= 1'b0;
        end else if (w_active) begin
            r_pc_prev <= pc_i;
            r_pc_vld  <= 1'b1;
            if (w_wr_nz) begin
                r_mask[rf_waddr_i] <= 1'b1;
            end
        end
    end

    assign done_o         = (r_state == StPass) || (r_state == StFail);
    assign pass_o         = (r_state == StPass);
    assign fail_o         = (r_state == StFail);
    assign timeout_o      = r_timeout;
    assign hang_o         = r_hang;
    assign cycle_cnt_o    = w_cyc;
    assign wr_cnt_o       = w_wr;
    assign final_val_o    = r_final;
    assign written_mask_o = r_mask;
    assign state_o        = r_state;

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

    localparam int LEN     = 64;
    localparam int TIMEOUT = 50;
    localparam int STALL   = 8;
    localparam int DONE    = 9;
    localparam int EXPV    = 42;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rf_we_i = 1'b0;
    logic [4:0]  rf_waddr_i = '0;
    logic [31:0] rf_wdata_i = '0;
    logic [31:0] pc_i = '0;
    logic        done_o, pass_o, fail_o, timeout_o, hang_o;
    logic [15:0] cycle_cnt_o, wr_cnt_o;
    logic [31:0] final_val_o;
    logic [31:0] written_mask_o;
    logic [1:0]  state_o;

    int n_total = 0;
    int n_bad   = 0;

    logic        t_we   [LEN];
    logic [4:0]  t_addr [LEN];
    logic [31:0] t_data [LEN];
    logic [31:0] t_pc   [LEN];

    always #5 clk = ~clk;

    run_monitor #(
        .XLEN           (32),
        .REG_ADDR_W     (5),
        .DONE_REG       (DONE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .STALL_LIMIT    (STALL),
        .CNT_W          (16),
        .CHECK_EN       (1),
        .EXPECT_VAL     (EXPV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rf_we_i        (rf_we_i),
        .rf_waddr_i     (rf_waddr_i),
        .rf_wdata_i     (rf_wdata_i),
        .pc_i           (pc_i),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .fail_o         (fail_o),
        .timeout_o      (timeout_o),
        .hang_o         (hang_o),
        .cycle_cnt_o    (cycle_cnt_o),
        .wr_cnt_o       (wr_cnt_o),
        .final_val_o    (final_val_o),
        .written_mask_o (written_mask_o),
        .state_o        (state_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "/state"}, 64'(state_o), 0);
        check_eq({tag, "/done"}, 64'(done_o), 0);
        check_eq({tag, "/pass"}, 64'(pass_o), 0);
        check_eq({tag, "/fail"}, 64'(fail_o), 0);
        check_eq({tag, "/timeout"}, 64'(timeout_o), 0);
        check_eq({tag, "/hang"}, 64'(hang_o), 0);
        check_eq({tag, "/cycles"}, 64'(cycle_cnt_o), 0);
        check_eq({tag, "/writes"}, 64'(wr_cnt_o), 0);
        check_eq({tag, "/final"}, 64'(final_val_o), 0);
        check_eq({tag, "/mask"}, 64'(written_mask_o), 0);
    endtask

    task automatic clear_trace();
        for (int i = 0; i < LEN; i++) begin
            t_we[i]   = 1'b0;
            t_addr[i] = '0;
            t_data[i] = '0;
            t_pc[i]   = 32'h100 + 32'(4 * i);
        end
    endtask

    task automatic put_wr(input int c, input int a, input int d);
        t_we[c]   = 1'b1;
        t_addr[c] = 5'(a);
        t_data[c] = 32'(d);
    endtask

    task automatic hold_pc(input int first, input int last, input int val);
        for (int i = first; i <= last; i++) t_pc[i] = 32'(val);
    endtask

    task automatic drive(input int c);
        if (c < LEN) begin
            rf_we_i    = t_we[c];
            rf_waddr_i = t_addr[c];
            rf_wdata_i = t_data[c];
            pc_i       = t_pc[c];
        end else begin
            rf_we_i    = 1'b0;
            rf_waddr_i = '0;
            rf_wdata_i = '0;
        end
    endtask

    // Model: find the cycle where the run ends and its cause, then derive everything
    // observable from that. cause: 0 = DONE_REG write, 1 = timeout, 2 = hang.
    task automatic run_trace(input string name, input bit rst_in_drain);
        int t, cause, run, last, exp_wr, exp_state, exp_cnt;
        logic [31:0] exp_mask, exp_final;
        bit pass_exp;
        t = TIMEOUT - 1;
        cause = 1;
        run = 0;
        for (int c = 0; c < TIMEOUT; c++) begin
            if (c > 0 && t_pc[c] == t_pc[c-1]) run++;
            else run = 0;
            if (t_we[c] && t_addr[c] == 5'(DONE)) begin
                t = c; cause = 0; break;
            end
            if (c == TIMEOUT - 1) begin
                t = c; cause = 1; break;
            end
            if (run >= STALL) begin
                t = c; cause = 2; break;
            end
        end
        last = (cause == 0) ? t + 1 : t;
        exp_wr = 0;
        exp_mask = '0;
        for (int c = 0; c <= last; c++) begin
            if (t_we[c] && t_addr[c] != 0) begin
                exp_wr++;
                exp_mask[t_addr[c]] = 1'b1;
            end
        end
        exp_final = (cause == 0) ? t_data[t] : 32'd0;
        pass_exp  = (cause == 0) && (exp_final == 32'(EXPV));

        reset = 1'b1;
        #1;
        check_zero({name, "/rst"});
        @(posedge clk);
        #1;
        drive(0);
        #1 reset = 1'b0;
        for (int c = 0; c < LEN; c++) begin
            @(negedge clk);
            if (c <= t) begin
                exp_state = 0; exp_cnt = c;
            end else if (cause == 0 && c == t + 1) begin
                exp_state = 1; exp_cnt = t + 1;
            end else if (cause == 0) begin
                exp_state = pass_exp ? 2 : 3; exp_cnt = t + 2;
            end else begin
                exp_state = 3; exp_cnt = t;
            end
            check_eq({name, "/state"}, 64'(state_o), 64'(exp_state));
            check_eq({name, "/cyc"}, 64'(cycle_cnt_o), 64'(exp_cnt));
            if (rst_in_drain && cause == 0 && c == t + 1) begin
                #1 reset = 1'b1;
                #1;
                check_zero({name, "/async"});
                return;
            end
            @(posedge clk);
            #1;
            drive(c + 1);
        end
        @(negedge clk);
        check_eq({name, "/done"}, 64'(done_o), 1);
        check_eq({name, "/pass"}, 64'(pass_o), 64'(pass_exp));
        check_eq({name, "/fail"}, 64'(fail_o), 64'(!pass_exp));
        check_eq({name, "/timeout"}, 64'(timeout_o), 64'(cause == 1));
        check_eq({name, "/hang"}, 64'(hang_o), 64'(cause == 2));
        check_eq({name, "/writes"}, 64'(wr_cnt_o), 64'(exp_wr));
        check_eq({name, "/final"}, 64'(final_val_o), 64'(exp_final));
        check_eq({name, "/mask"}, 64'(written_mask_o), 64'(exp_mask));
    endtask

    task automatic random_trace();
        int a, h0, hl;
        for (int i = 0; i < LEN; i++) begin
            t_we[i] = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 15));
            if (a == DONE && $urandom_range(0, 7) != 0) a = 10;
            t_addr[i] = 5'(a);
            t_data[i] = ($urandom_range(0, 1) != 0) ? 32'(EXPV) : $urandom;
            if (i == 0) t_pc[i] = $urandom;
            else if ($urandom_range(0, 9) < 3) t_pc[i] = t_pc[i-1];
            else t_pc[i] = t_pc[i-1] + 32'd4;
        end
        if ($urandom_range(0, 1) != 0) begin
            h0 = int'($urandom_range(0, 45));
            hl = int'($urandom_range(5, 10));
            for (int j = h0 + 1; j <= h0 + hl && j < LEN; j++) t_pc[j] = t_pc[h0];
        end
    endtask

    initial begin
        // x1..x8 then x9=42 at cycle 20: DRAIN at 21, PASS at 22
        clear_trace();
        for (int i = 1; i <= 8; i++) put_wr(i + 1, i, i * 3);
        put_wr(20, 9, 42);
        run_trace("pass42", 1'b0);

        // wrong final value with checking enabled
        clear_trace();
        put_wr(15, 9, 8);
        run_trace("badval", 1'b0);

        // no DONE_REG write: timeout with x0 writes ignored
        clear_trace();
        put_wr(3, 0, 5);
        put_wr(4, 5, 6);
        put_wr(30, 0, 7);
        run_trace("timeout", 1'b0);

        // PC equal to previous for 8 cycles starting at cycle 5
        clear_trace();
        hold_pc(4, 12, 32'h10);
        run_trace("hang8", 1'b0);

        // only 7 stall cycles then a change: no hang
        clear_trace();
        hold_pc(4, 11, 32'h10);
        run_trace("hold7", 1'b0);

        // DONE_REG write on the timeout cycle wins
        clear_trace();
        put_wr(49, 9, 42);
        run_trace("done_at_to", 1'b0);

        // DONE_REG write on the hang cycle wins
        clear_trace();
        hold_pc(4, 12, 32'h10);
        put_wr(12, 9, 42);
        run_trace("done_at_hang", 1'b0);

        // timeout and hang on the same cycle: timeout wins
        clear_trace();
        hold_pc(41, 49, 32'h40);
        run_trace("to_vs_hang", 1'b0);

        // writes in DRAIN: mask/count update, final value unchanged
        clear_trace();
        put_wr(10, 9, 42);
        put_wr(11, 9, 77);
        run_trace("drain_wr9", 1'b0);
        clear_trace();
        put_wr(10, 9, 42);
        put_wr(11, 3, 77);
        run_trace("drain_wr3", 1'b0);

        // PC of 0 from the first cycle: the first cycle is not a stall
        clear_trace();
        hold_pc(0, 9, 0);
        run_trace("pc0_start", 1'b0);

        // reset during DRAIN, then a fresh run
        clear_trace();
        put_wr(20, 9, 42);
        run_trace("drain_rst", 1'b1);
        run_trace("after_rst", 1'b0);

        for (int k = 0; k < 40; k++) begin
            random_trace();
            run_trace($sformatf("rand%0d", k), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
